// File: rtl/row_fetcher_pkg.sv
// Constants shared by the row fetcher and the downstream bit-extraction stage.
// Both stages derive their widths and wrap points from these values.
package row_fetcher_pkg;
   localparam int ROW_BITS  = 1280;
   localparam int WORD_BITS = 32;
   localparam int ROWS      = 720;
   localparam int ADDR_W    = 16;
   localparam int WORDS     = ROW_BITS / WORD_BITS;
   localparam int ROW_NUM_W = $clog2(ROWS);
   localparam int WIDX_W    = $clog2(WORDS);

   function automatic logic [ROW_NUM_W-1:0] next_row(input logic [ROW_NUM_W-1:0] r);
      return (r == ROW_NUM_W'(ROWS - 1)) ? '0 : r + ROW_NUM_W'(1);
   endfunction
endpackage

// File: rtl/row_fetcher_packer.sv
// Back buffer: drops one RAM word per write into its slot of the assembled row.
// row_nxt_o already includes this cycle's write, so a swap can take the final word on the same edge.
module row_packer
   import row_fetcher_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wr_en_i,
   input  logic [WIDX_W-1:0]    wr_idx_i,
   input  logic [WORD_BITS-1:0] wr_word_i,
   output logic [ROW_BITS-1:0]  row_nxt_o
);
   logic [ROW_BITS-1:0] row_q;
   logic [ROW_BITS-1:0] row_d;

   always_comb begin
      row_d = row_q;
      if (wr_en_i) begin
         row_d[int'(wr_idx_i) * WORD_BITS +: WORD_BITS] = wr_word_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   assign row_nxt_o = row_d;
endmodule

// File: rtl/row_fetcher.sv
// Double-buffered row fetcher: streams WORDS reads per row from the frame RAM into a back buffer.
// First row visible WORDS+1 cycles after reset; the downstream advance is never stalled, early ones flag underrun.
module row_fetcher
   import row_fetcher_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   output logic                 ram_rd_en,
   output logic [ADDR_W-1:0]    ram_addr,
   input  logic [WORD_BITS-1:0] ram_rdata,
   input  logic                 row_advance,
   output logic [ROW_BITS-1:0]  row_data,
   output logic                 row_valid,
   output logic [ROW_NUM_W-1:0] row_num,
   output logic                 underrun
);
   typedef enum logic [1:0] {FETCH, DRAIN, FULL} state_t;

   state_t               state_q;
   logic                 rd_en_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [WIDX_W-1:0]    widx_q;
   logic                 wr_en_q;
   logic [WIDX_W-1:0]    wr_idx_q;
   logic [ROW_NUM_W-1:0] frow_q;
   logic [ROW_NUM_W-1:0] row_num_q;
   logic [ROW_BITS-1:0]  front_q;
   logic                 row_valid_q;
   logic                 underrun_q;
   logic                 pend_q;
   logic [ROW_BITS-1:0]  back_row;
   logic                 swap;

   row_packer u_packer (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (wr_en_q),
      .wr_idx_i  (wr_idx_q),
      .wr_word_i (ram_rdata),
      .row_nxt_o (back_row)
   );

   // An advance seen during DRAIN lands on the edge that would enter FULL, so it is timely.
   always_comb begin
      swap = 1'b0;
      case (state_q)
         DRAIN:   swap = !row_valid_q || pend_q || row_advance;
         FULL:    swap = row_advance;
         default: swap = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FETCH;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         widx_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_idx_q    <= '0;
         frow_q      <= '0;
         row_num_q   <= '0;
         front_q     <= '0;
         row_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         wr_en_q  <= rd_en_q;
         wr_idx_q <= widx_q;

         if (row_advance && (state_q == FETCH || !row_valid_q)) begin
            underrun_q <= 1'b1;
         end
         if (row_advance && state_q == FETCH) begin
            pend_q <= 1'b1;
         end

         case (state_q)
            FETCH: begin
               // Only the first cycle out of reset reaches FETCH with the strobe low.
               if (!rd_en_q) begin
                  rd_en_q <= 1'b1;
               end else if (widx_q == WIDX_W'(WORDS - 1)) begin
                  rd_en_q <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  widx_q <= widx_q + WIDX_W'(1);
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (!swap) begin
                  state_q <= FULL;
               end
            end
            default: ;
         endcase

         if (swap) begin
            front_q     <= back_row;
            row_num_q   <= frow_q;
            row_valid_q <= 1'b1;
            pend_q      <= 1'b0;
            frow_q      <= next_row(frow_q);
            addr_q      <= (frow_q == ROW_NUM_W'(ROWS - 1)) ? '0 : addr_q + ADDR_W'(1);
            widx_q      <= '0;
            rd_en_q     <= 1'b1;
            state_q     <= FETCH;
         end
      end
   end

   assign ram_rd_en = rd_en_q;
   assign ram_addr  = addr_q;
   assign row_data  = front_q;
   assign row_valid = row_valid_q;
   assign row_num   = row_num_q;
   assign underrun  = underrun_q;
endmodule

// File: tb/tb_row_fetcher.sv
// Bench for row_fetcher: RAM model returns data = address; address and row scoreboards run alongside directed sequences.
module tb_row_fetcher;
   localparam int RB    = 1280;
   localparam int NW    = 40;
   localparam int NROWS = 720;
   localparam int LAST_ADDR = NROWS * NW - 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            ram_rd_en;
   logic [15:0]     ram_addr;
   logic [31:0]     ram_rdata = '0;
   logic            row_advance = 1'b0;
   logic [RB-1:0]   row_data;
   logic            row_valid;
   logic [9:0]      row_num;
   logic            underrun;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int nxt_row = 0;
   int exp_addr = 0;
   bit prev_valid = 1'b0;
   int prev_num = 0;
   bit saw_row_wrap = 1'b0;
   bit saw_addr_wrap = 1'b0;

   typedef struct {
      int          k;
      logic [31:0] word;
   } wvec_t;
   wvec_t wtab[5];

   row_fetcher dut (
      .clk         (clk),
      .reset       (reset),
      .ram_rd_en   (ram_rd_en),
      .ram_addr    (ram_addr),
      .ram_rdata   (ram_rdata),
      .row_advance (row_advance),
      .row_data    (row_data),
      .row_valid   (row_valid),
      .row_num     (row_num),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rdata <= 32'(ram_addr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, req);
      end
   endtask

   // Address and row scoreboards
   always @(negedge clk) begin
      int e;
      if (reset) begin
         exp_addr = 0;
         prev_valid = 1'b0;
         prev_num = 0;
      end else begin
         if (ram_rd_en) begin
            chk("rd_addr", 64'(ram_addr), 64'(exp_addr));
            if (exp_addr == LAST_ADDR) begin
               saw_addr_wrap = 1'b1;
               exp_addr = 0;
            end else begin
               exp_addr++;
            end
         end
         if (prev_valid) chk("row_valid_held", 64'(row_valid), 64'd1);
         if (row_valid && (!prev_valid || int'(row_num) != prev_num)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_swap: actual row %0d required no swap", row_num);
            end else begin
               e = exp_q.pop_front();
               chk("swap_row_num", 64'(row_num), 64'(e));
               chk("swap_word0", 64'(row_data[31:0]), 64'(e * NW));
               chk("swap_wlast", 64'(row_data[RB-1 -: 32]), 64'(e * NW + NW - 1));
               if (prev_valid && prev_num == NROWS - 1 && row_num == 0) saw_row_wrap = 1'b1;
            end
         end
         prev_valid = row_valid;
         prev_num = int'(row_num);
      end
   end

   task automatic check_words(input int row);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("row%0d_word%0d", row, wtab[i].k),
             64'(row_data[wtab[i].k * 32 +: 32]), 64'(wtab[i].word + 32'(row * NW)));
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rd_en"}, 64'(ram_rd_en), 64'd0);
      chk({tag, "_addr"}, 64'(ram_addr), 64'd0);
      chk({tag, "_data_zero"}, 64'(row_data == '0), 64'd1);
      chk({tag, "_valid"}, 64'(row_valid), 64'd0);
      chk({tag, "_row_num"}, 64'(row_num), 64'd0);
      chk({tag, "_underrun"}, 64'(underrun), 64'd0);
   endtask

   task automatic first_row_check();
      int first = -1;
      int reads = 0;
      bit rd0 = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c == 0) rd0 = ram_rd_en;
         if (c <= 40 && ram_rd_en) reads++;
         if (row_valid && first < 0) first = c;
      end
      chk("first_rd_en_cycle0", 64'(rd0), 64'd1);
      chk("reads_row0", 64'(reads), 64'd40);
      chk("first_valid_cycle", 64'(first), 64'd41);
      chk("row_num0", 64'(row_num), 64'd0);
      check_words(0);
   endtask

   task automatic wait_drain();
      bit seen = 1'b0;
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (ram_rd_en) seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL wait_drain: actual no fetch end required one within 200 cycles");
      end
   endtask

   task automatic advance(input bit expect_swap);
      row_advance = 1'b1;
      if (expect_swap) begin
         exp_q.push_back(nxt_row);
         nxt_row = (nxt_row + 1) % NROWS;
      end
      @(negedge clk);
      row_advance = 1'b0;
   endtask

   initial begin
      bit found;
      wtab[0] = '{0, 32'd0};
      wtab[1] = '{1, 32'd1};
      wtab[2] = '{17, 32'd17};
      wtab[3] = '{38, 32'd38};
      wtab[4] = '{39, 32'd39};

      repeat (2) @(negedge clk);
      check_reset("por");
      exp_q.push_back(0);
      nxt_row = 1;
      reset = 1'b0;
      first_row_check();
      chk("row0_underrun", 64'(underrun), 64'd0);

      // Advance while FULL
      wait_drain();
      @(negedge clk);
      advance(1'b1);
      chk("adv_row_num", 64'(row_num), 64'd1);
      chk("adv_underrun", 64'(underrun), 64'd0);
      chk("adv_next_rd", 64'(ram_rd_en), 64'd1);
      chk("adv_next_addr", 64'(ram_addr), 64'd80);
      check_words(1);

      // Advance on the edge that enters FULL
      wait_drain();
      advance(1'b1);
      chk("edge_row_num", 64'(row_num), 64'd2);
      chk("edge_underrun", 64'(underrun), 64'd0);
      chk("edge_next_addr", 64'(ram_addr), 64'd120);

      // Early advances during a fetch
      repeat (10) @(negedge clk);
      advance(1'b1);
      chk("early_underrun", 64'(underrun), 64'd1);
      chk("early_row_num", 64'(row_num), 64'd2);
      repeat (2) @(negedge clk);
      advance(1'b0);
      chk("early2_underrun", 64'(underrun), 64'd1);
      wait_drain();
      chk("drain_row_num", 64'(row_num), 64'd2);
      @(negedge clk);
      chk("pend_swap_row_num", 64'(row_num), 64'd3);
      wait_drain();
      repeat (4) @(negedge clk);
      chk("single_swap_row_num", 64'(row_num), 64'd3);
      chk("single_swap_valid", 64'(row_valid), 64'd1);
      chk("sticky_underrun", 64'(underrun), 64'd1);

      // Full frame with timely advances
      for (int i = 0; i < NROWS; i++) begin
         if (i != 0) begin
            wait_drain();
            if (i % 2 == 0) @(negedge clk);
         end
         advance(1'b1);
      end
      chk("frame_row_num", 64'(row_num), 64'd3);
      chk("row_wrap_seen", 64'(saw_row_wrap), 64'd1);
      chk("addr_wrap_seen", 64'(saw_addr_wrap), 64'd1);

      // Reset in the middle of a fetch
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (ram_rd_en && (ram_addr % 40) == 20) found = 1'b1;
      end
      chk("mid_fetch_found", 64'(found), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset("mid");
      exp_q.delete();
      repeat (2) @(negedge clk);
      exp_q.push_back(0);
      nxt_row = 1;
      reset = 1'b0;
      first_row_check();
      chk("rst_underrun", 64'(underrun), 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: actual timeout required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
